bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
// Shares the core's single memory bus between instruction fetch (IF, read-only) and load/store (LS).
// Accepts one request at a time from either requester, drives it onto the bus, and routes the response back to its owner.
// LS has priority. A starvation counter guarantees IF forward progress. A response timeout prevents bus hangs.
// One transaction outstanding at a time; sits between fetch/execute stages and the bus master port.
// PARAMETERS
// ADDR_W        32   address width
// DATA_W        32   data width; STRB_W = DATA_W/8
// STARVE_LIMIT  4    consecutive LS grants while IF waits before IF is forced through; 0 = strict LS priority
// TIMEOUT       255  cycles in RESP before error response; 0 = no timeout
// PORTS
// clock           in   1       system clock, rising edge
// reset           in   1       asynchronous, active-low reset
// if_req_valid    in   1       IF request valid
// if_req_ready    out  1       IF request accepted this cycle
// if_addr         in   ADDR_W  IF read address
// if_resp_valid   out  1       IF response pulse
// if_resp_data    out  DATA_W  IF read data
// if_resp_err     out  1       IF response error
// ls_req_valid    in   1       LS request valid
// ls_req_ready    out  1       LS request accepted this cycle
// ls_addr         in   ADDR_W  LS address
// ls_wdata        in   DATA_W  LS write data
// ls_we           in   1       1 = write, 0 = read
// ls_strb         in   STRB_W  LS byte enables
// ls_resp_valid   out  1       LS response pulse
// ls_resp_data    out  DATA_W  LS read data
// ls_resp_err     out  1       LS response error
// bus_valid       out  1       request presented to bus
// bus_ready       in   1       bus accepts request
// bus_addr/wdata/we/strb  out  ADDR_W/DATA_W/1/STRB_W  latched request fields
// bus_resp_valid  in   1       bus response valid
// bus_resp_data   in   DATA_W  bus read data
// bus_resp_err    in   1       bus error
// busy            out  1       state != IDLE
// BEHAVIOUR
// - Reset (async, reset==0): state IDLE, starve_cnt=0, tmo_cnt=0, owner=IF, all valid/ready/err outputs 0, bus_* fields 0.
// - FSM states IDLE -> ADDR -> RESP -> IDLE.
// - IDLE, grant: if only one requester is valid, that requester wins.
//   If both are valid, IF wins iff STARVE_LIMIT!=0 && starve_cnt>=STARVE_LIMIT; otherwise LS wins.
// - IDLE, accept: the winner's *_req_ready=1 combinationally that cycle (handshake = valid&&ready).
//   On the edge: latch owner and bus fields, go to ADDR. The loser's ready=0.
//   IF requests latch we=0, strb=all ones, wdata=0.
// - *_req_ready is 0 in ADDR/RESP. Requesters hold valid and fields stable until accepted.
// - starve_cnt: +1 (saturating at STARVE_LIMIT) when LS is granted while if_req_valid=1; cleared when IF is granted.
// - ADDR: bus_valid=1 with fields stable until bus_ready. On bus_ready go to RESP, tmo_cnt=0.
//   If bus_resp_valid also =1 that cycle, complete immediately: deliver response, go to IDLE.
// - RESP: bus_valid=0; tmo_cnt increments each cycle.
//   On bus_resp_valid: owner's *_resp_valid=1 for one cycle (registered, the cycle after capture), with data/err; go to IDLE.
// - Timeout: TIMEOUT!=0 and tmo_cnt reaches TIMEOUT with no response -> owner receives resp_valid=1, err=1, data=0; go to IDLE.
// - bus_resp_valid in IDLE, or in ADDR without bus_ready, is ignored (stale or late responses are dropped).
// - No response backpressure: requesters must accept *_resp_valid pulses.
// - Minimum turnaround: the next grant may occur in the same cycle the response pulse is output.
// - Reset mid-transaction aborts it: no response is issued, and the requester must reissue.
// TESTING
// 1 IF only, if_addr=0x100; bus_ready 1 cycle later, data 0xDEADBEEF 2 cycles later -> bus_addr=0x100, we=0, strb=4'hF; one if_resp_valid pulse with 0xDEADBEEF; ls_resp_valid stays 0.
// 2 STARVE_LIMIT=2, both valid continuously, 1-cycle bus -> grant order LS,LS,IF,LS,LS,IF; STARVE_LIMIT=0 -> LS only.
// 3 LS store addr=0x2000, wdata=0x1234ABCD, strb=4'b0011 with IF also valid -> bus shows exactly those fields; IF ready held 0 until the LS response.
// 4 TIMEOUT=8, bus never responds -> ls_resp_valid with err=1, data=0, 8 cycles after entering RESP; a later bus_resp_valid is ignored.
// 5 Assert reset while in RESP -> all outputs 0 immediately, busy=0; the stale response is dropped; next IF request completes normally.
// 6 bus_ready and bus_resp_valid in the same ADDR cycle (data 0x55) -> owner gets 0x55; back to IDLE; next request is granted next cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between instruction fetch (read-only)
// and load/store. Load/store has priority, a starvation counter lets fetch
// through after STARVE_LIMIT consecutive load/store wins, and a response
// timeout turns a silent bus into an error response. One transaction is
// outstanding at a time: IDLE -> ADDR -> RESP -> IDLE.
module bus_arbiter #(
    parameter  int ADDR_W       = 32,
    parameter  int DATA_W       = 32,
    parameter  int STARVE_LIMIT = 4,
    parameter  int TIMEOUT      = 255,
    localparam int STRB_W       = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    // instruction fetch requester
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    output logic              if_resp_err,
    // load/store requester
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              ls_we,
    input  logic [STRB_W-1:0] ls_strb,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_resp_data,
    output logic              ls_resp_err,
    // bus master port
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic [STRB_W-1:0] bus_strb,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_resp_data,
    input  logic              bus_resp_err,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    // Last count value in RESP; the timeout fires on the edge that would
    // take tmo_cnt to TIMEOUT.
    localparam logic [TC_W-1:0] TMO_LAST   = TC_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic            owner;
    logic [SC_W-1:0] starve_cnt;
    logic [TC_W-1:0] tmo_cnt;

    logic force_if;
    logic grant_if;
    logic grant_ls;
    logic resp_done;
    logic resp_timeout;

    // Arbitration and response detection for the current cycle.
    // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
    always_comb begin
        // starve_cnt saturates at STARVE_MAX, so equality is the threshold test
        force_if     = (STARVE_LIMIT != 0) && (starve_cnt == STARVE_MAX);
        grant_if     = (state == IDLE) && if_req_valid && (!ls_req_valid || force_if);
        grant_ls     = (state == IDLE) && ls_req_valid && !grant_if;
        // a response is only taken once the request itself has been accepted
        resp_done    = ((state == ADDR) && bus_ready && bus_resp_valid) ||
                       ((state == RESP) && bus_resp_valid);
        resp_timeout = (state == RESP) && !bus_resp_valid && (TIMEOUT != 0) &&
                       (tmo_cnt == TMO_LAST);
    end

    // Request-side handshakes and status; ready is held low while reset is asserted.
    assign if_req_ready = reset && grant_if;
    assign ls_req_ready = reset && grant_ls;
    assign bus_valid    = (state == ADDR);
    assign busy         = (state != IDLE);

    // Transaction FSM: grant, latch request fields, track starvation and timeout.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWNER_IF;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_we     <= 1'b0;
            bus_strb   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        owner      <= OWNER_IF;
                        bus_addr   <= if_addr;
                        bus_wdata  <= '0;
                        bus_we     <= 1'b0;
                        bus_strb   <= '1;
                        starve_cnt <= '0;
                        state      <= ADDR;
                    end else if (grant_ls) begin
                        owner     <= OWNER_LS;
                        bus_addr  <= ls_addr;
                        bus_wdata <= ls_wdata;
                        bus_we    <= ls_we;
                        bus_strb  <= ls_strb;
                        if (if_req_valid && (starve_cnt != STARVE_MAX))
                            starve_cnt <= starve_cnt + 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_ready) begin
                        tmo_cnt <= '0;
                        state   <= bus_resp_valid ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (bus_resp_valid || resp_timeout)
                        state <= IDLE;
                    else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered one-cycle response pulse routed to the transaction owner.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            if_resp_err   <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
            ls_resp_err   <= 1'b0;
        end else begin
            if_resp_valid <= 1'b0;
            if_resp_err   <= 1'b0;
            ls_resp_valid <= 1'b0;
            ls_resp_err   <= 1'b0;
            if (resp_done || resp_timeout) begin
                if (owner == OWNER_LS) begin
                    ls_resp_valid <= 1'b1;
                    ls_resp_data  <= resp_timeout ? '0 : bus_resp_data;
                    ls_resp_err   <= resp_timeout || bus_resp_err;
                end else begin
                    if_resp_valid <= 1'b1;
                    if_resp_data  <= resp_timeout ? '0 : bus_resp_data;
                    if_resp_err   <= resp_timeout || bus_resp_err;
                end
            end
        end
    end

endmodule
